multicycle_main_fsm: RTL

Main control state machine for the multicycle RV32I core. It sequences the shared ALU, unified instruction/data memory port, instruction register and register-file write across several cycles per instruction, driving the datapath select/enable lines from the current state and the latched 7-bit opcode. It sits beside the ALU decoder, which consumes its `o_ALUOp`, and replaces the single-cycle main decoder's one-shot control word with a per-state control word.

---
 rtl/multicycle_main_fsm.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core: per-state Moore control word for the
// shared ALU, unified memory port, IR and register file. Optional macro: MULTICYCLE_ILLEGAL_TRAP_EN.
module multicycle_main_fsm (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [6:0] i_OpCode,
  input  logic       i_MemReady,
  output logic       o_MemReq,
  output logic       o_AdrSrc,
  output logic       o_IRWrite,
  output logic       o_PCUpdate,
  output logic       o_Branch,
  output logic       o_MemWrite,
  output logic       o_RegWrite,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_ResultSrc,
  output logic [1:0] o_ALUOp,
  output logic [1:0] o_ImmSrc,
  output logic       o_Retire,
  output logic       o_IllegalInstr
);

  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  typedef enum logic [3:0] {
    Fetch, Decode, MemAdr, MemRead, MemWb, MemWrite,
    ExecR, ExecI, AluWb, Beq, Jal, Trap
  } state_t;

  state_t state, stateNext;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) state <= Fetch;
    else          state <= stateNext;
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic illegalQ;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n)               illegalQ <= 1'b0;
    else if (stateNext == Trap) illegalQ <= 1'b1;
  end
`endif

  always_comb begin
    stateNext = state;
    unique case (state)
      Fetch:    if (i_MemReady) stateNext = Decode;
      Decode: begin
        case (i_OpCode)
          OpLw, OpSw: stateNext = MemAdr;
          OpRType:    stateNext = ExecR;
          OpIType:    stateNext = ExecI;
          OpBeq:      stateNext = Beq;
          OpJal:      stateNext = Jal;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:    stateNext = Trap;
`else
          default:    stateNext = Fetch;
`endif
        endcase
      end
      MemAdr:             stateNext = (i_OpCode == OpSw) ? MemWrite : MemRead;
      MemRead:            if (i_MemReady) stateNext = MemWb;
      MemWrite:           if (i_MemReady) stateNext = Fetch;
      ExecR, ExecI, Jal:  stateNext = AluWb;
      MemWb, AluWb, Beq:  stateNext = Fetch;
      Trap:               stateNext = Trap;
      default:            stateNext = Fetch;
    endcase
  end

  // NOTE: every output gets a default before the case so no field can infer a latch.
  always_comb begin
    o_MemReq       = 1'b0;
    o_AdrSrc       = 1'b0;
    o_IRWrite      = 1'b0;
    o_PCUpdate     = 1'b0;
    o_Branch       = 1'b0;
    o_MemWrite     = 1'b0;
    o_RegWrite     = 1'b0;
    o_ALUSrcA      = 2'b00;
    o_ALUSrcB      = 2'b00;
    o_ResultSrc    = 2'b00;
    o_ALUOp        = 2'b00;
    o_ImmSrc       = 2'b00;
    o_Retire       = 1'b0;
    o_IllegalInstr = 1'b0;
    // Reset low silences the whole control word, so an abandoned instruction cannot write.
    if (i_Rst_n) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      o_IllegalInstr = illegalQ;
`endif
      if (state != Trap) begin
        case (i_OpCode)
          OpSw:    o_ImmSrc = 2'b01;
          OpBeq:   o_ImmSrc = 2'b10;
          OpJal:   o_ImmSrc = 2'b11;
          default: o_ImmSrc = 2'b00;
        endcase
      end
      unique case (state)
        Fetch: begin
          o_MemReq    = 1'b1;
          o_ALUSrcB   = 2'b10;
          o_ResultSrc = 2'b10;
          o_IRWrite   = i_MemReady;
          o_PCUpdate  = i_MemReady;
        end
        Decode: begin
          o_ALUSrcA = 2'b01;
          o_ALUSrcB = 2'b01;
        end
        MemAdr: begin
          o_ALUSrcA = 2'b10;
          o_ALUSrcB = 2'b01;
        end
        MemRead: begin
          o_MemReq = 1'b1;
          o_AdrSrc = 1'b1;
        end
        MemWb: begin
          o_ResultSrc = 2'b01;
          o_RegWrite  = 1'b1;
          o_Retire    = 1'b1;
        end
        MemWrite: begin
          o_MemReq   = 1'b1;
          o_AdrSrc   = 1'b1;
          o_MemWrite = 1'b1;
          o_Retire   = i_MemReady;
        end
        ExecR: begin
          o_ALUSrcA = 2'b10;
          o_ALUOp   = 2'b10;
        end
        ExecI: begin
          o_ALUSrcA = 2'b10;
          o_ALUSrcB = 2'b01;
          o_ALUOp   = 2'b10;
        end
        AluWb: begin
          o_RegWrite = 1'b1;
          o_Retire   = 1'b1;
        end
        Beq: begin
          o_ALUSrcA = 2'b10;
          o_ALUOp   = 2'b01;
          o_Branch  = 1'b1;
          o_Retire  = 1'b1;
        end
        Jal: begin
          o_ALUSrcA  = 2'b01;
          o_ALUSrcB  = 2'b10;
          o_PCUpdate = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
